// File: rtl/aes_pkg.sv
// Shared definitions for the AES input/output word buffers: FSM encoding and
// block/word geometry.
package aes_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned WORD_COUNT = 4;
  localparam int unsigned BLOCK_W    = WORD_W * WORD_COUNT;
  localparam int unsigned IDX_W      = 2;

  localparam logic [IDX_W-1:0] FIRST_IDX = 2'd0;
  localparam logic [IDX_W-1:0] LAST_IDX  = 2'd3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } aes_state_e;

endpackage : aes_pkg

// File: rtl/aes_output_buffer.sv
// Holds one 128-bit AES result and streams it out as four 32-bit words with
// valid/ready handshaking; all outputs are registered.
module aes_output_buffer
  import aes_pkg::*;
#(
  parameter logic MSW_FIRST = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               done_i,
  input  logic [BLOCK_W-1:0] text_in,
  input  logic               ready_i,
  output logic [WORD_W-1:0]  text_o,
  output logic               valid_o,
  output logic               last_o,
  output logic               busy_o,
  output logic               ovf_o
);

  aes_state_e         state_r, state_s;
  logic [IDX_W-1:0]   idx_r, idx_s;
  logic [BLOCK_W-1:0] hold_r, hold_s;
  logic               ovf_r, ovf_s;
  logic [WORD_W-1:0]  text_r, text_s;
  logic               valid_r, valid_s;
  logic               last_r, last_s;
  logic               busy_r, busy_s;
  logic               xfer_s;
  logic [IDX_W-1:0]   sel_s;
  logic [WORD_W-1:0]  word_s;

  assign xfer_s = (state_r == SEND) && ready_i;

  // Next-state, word index, holding register and overflow flag.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    hold_s  = hold_r;
    ovf_s   = ovf_r;
    case (state_r)
      IDLE: begin
        if (done_i) begin
          hold_s  = text_in;
          idx_s   = FIRST_IDX;
          state_s = SEND;
        end else begin
          state_s = IDLE;
        end
      end
      SEND: begin
        if (xfer_s && (idx_r == LAST_IDX)) begin
          // A coincident done_i chains the next block with no idle bubble.
          if (done_i) begin
            hold_s  = text_in;
            idx_s   = FIRST_IDX;
            state_s = SEND;
          end else begin
            idx_s   = FIRST_IDX;
            state_s = IDLE;
          end
        end else begin
          if (xfer_s) begin
            idx_s = idx_r + 2'd1;
          end else begin
            idx_s = idx_r;
          end
          if (done_i) begin
            ovf_s = 1'b1;
          end else begin
            ovf_s = ovf_r;
          end
        end
      end
      default: begin
        state_s = IDLE;
        idx_s   = FIRST_IDX;
        hold_s  = {BLOCK_W{1'b0}};
      end
    endcase
  end

  // 4:1 word select on the next holding contents, honouring word order.
  always_comb begin
    if (MSW_FIRST) begin
      sel_s = LAST_IDX - idx_s;
    end else begin
      sel_s = idx_s;
    end
    case (sel_s)
      2'd0:    word_s = hold_s[31:0];
      2'd1:    word_s = hold_s[63:32];
      2'd2:    word_s = hold_s[95:64];
      2'd3:    word_s = hold_s[127:96];
      default: word_s = {WORD_W{1'b0}};
    endcase
  end

  // Output values for the next cycle, derived from the next state.
  always_comb begin
    if (state_s == SEND) begin
      valid_s = 1'b1;
      busy_s  = 1'b1;
      last_s  = (idx_s == LAST_IDX);
      text_s  = word_s;
    end else begin
      valid_s = 1'b0;
      busy_s  = 1'b0;
      last_s  = 1'b0;
      text_s  = {WORD_W{1'b0}};
    end
  end

  // State and output registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      idx_r   <= FIRST_IDX;
      hold_r  <= {BLOCK_W{1'b0}};
      ovf_r   <= 1'b0;
      text_r  <= {WORD_W{1'b0}};
      valid_r <= 1'b0;
      last_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      hold_r  <= hold_s;
      ovf_r   <= ovf_s;
      text_r  <= text_s;
      valid_r <= valid_s;
      last_r  <= last_s;
      busy_r  <= busy_s;
    end
  end

  assign text_o  = text_r;
  assign valid_o = valid_r;
  assign last_o  = last_r;
  assign busy_o  = busy_r;
  assign ovf_o   = ovf_r;

endmodule : aes_output_buffer

// File: tb/tb_aes_output_buffer.sv
// Scoreboard bench: two instances (LSW-first and MSW-first) share stimulus;
// expected words are queued at issue time and popped by a negedge monitor.
module tb_aes_output_buffer;

  logic         clk;
  logic         rst;
  logic         done_i;
  logic [127:0] text_in;
  logic         ready_i;
  logic [31:0]  text0, text1;
  logic         valid0, valid1, last0, last1, busy0, busy1, ovf0, ovf1;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [32:0] q0[$];
  logic [32:0] q1[$];

  localparam logic [127:0] BLK_A = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
  localparam logic [127:0] BLK_B = 128'h11111111_11111111_11111111_11111111;
  localparam logic [127:0] BLK_C = 128'hdeadbeef_cafef00d_01234567_89abcdef;
  localparam logic [127:0] BLK_D = 128'h00112233_44556677_8899aabb_ccddeeff;

  aes_output_buffer #(.MSW_FIRST(1'b0)) dut0 (
    .clk(clk), .rst(rst), .done_i(done_i), .text_in(text_in), .ready_i(ready_i),
    .text_o(text0), .valid_o(valid0), .last_o(last0), .busy_o(busy0), .ovf_o(ovf0)
  );

  aes_output_buffer #(.MSW_FIRST(1'b1)) dut1 (
    .clk(clk), .rst(rst), .done_i(done_i), .text_in(text_in), .ready_i(ready_i),
    .text_o(text1), .valid_o(valid1), .last_o(last1), .busy_o(busy1), .ovf_o(ovf1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Words are given in LSW-first order; dut1 expects the reverse.
  task automatic push_words(input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] w2, input logic [31:0] w3);
    q0.push_back({1'b0, w0}); q0.push_back({1'b0, w1});
    q0.push_back({1'b0, w2}); q0.push_back({1'b1, w3});
    q1.push_back({1'b0, w3}); q1.push_back({1'b0, w2});
    q1.push_back({1'b0, w1}); q1.push_back({1'b1, w0});
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_text0"}, text0, 32'h0);
    check({tag, "_valid0"}, {31'h0, valid0}, 32'h0);
    check({tag, "_last0"}, {31'h0, last0}, 32'h0);
    check({tag, "_busy0"}, {31'h0, busy0}, 32'h0);
    check({tag, "_ovf0"}, {31'h0, ovf0}, 32'h0);
    check({tag, "_text1"}, text1, 32'h0);
    check({tag, "_busy1"}, {31'h0, busy1}, 32'h0);
  endtask

  // Monitor: every accepted word must match the head of its scoreboard queue.
  always @(negedge clk) begin
    logic [32:0] e;
    if (rst && valid0 && ready_i) begin
      if (q0.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL sb0_unexpected: got word %h, expected none", text0);
      end else begin
        e = q0.pop_front();
        check("sb0_word", text0, e[31:0]);
        check("sb0_last", {31'h0, last0}, {31'h0, e[32]});
      end
    end
    if (rst && valid1 && ready_i) begin
      if (q1.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL sb1_unexpected: got word %h, expected none", text1);
      end else begin
        e = q1.pop_front();
        check("sb1_word", text1, e[31:0]);
        check("sb1_last", {31'h0, last1}, {31'h0, e[32]});
      end
    end
  end

  initial begin
    rst = 1'b0; done_i = 1'b0; text_in = 128'h0; ready_i = 1'b0;
    #1;
    check_zero("reset_async");
    cyc(2);
    rst = 1'b1;

    // Basic order, with done_i on the first edge after reset release.
    done_i = 1'b1; text_in = BLK_A; ready_i = 1'b1;
    push_words(32'h70b4c55a, 32'hd8cdb780, 32'h6a7b0430, 32'h69c4e0d8);
    cyc(1);
    done_i = 1'b0; text_in = 128'h0;
    check("lat_valid0", {31'h0, valid0}, 32'h1);
    check("lat_word0", text0, 32'h70b4c55a);
    check("lat_word1_msw", text1, 32'h69c4e0d8);
    check("lat_busy0", {31'h0, busy0}, 32'h1);
    cyc(4);
    check_zero("basic_end");

    // ready_i toggling in IDLE changes nothing.
    ready_i = 1'b0; cyc(1); ready_i = 1'b1; cyc(2);
    check_zero("idle_ready");

    // Backpressure on word 1.
    done_i = 1'b1; text_in = BLK_A;
    push_words(32'h70b4c55a, 32'hd8cdb780, 32'h6a7b0430, 32'h69c4e0d8);
    cyc(1);
    done_i = 1'b0;
    cyc(1);
    ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      check("bp_text", text0, 32'hd8cdb780);
      check("bp_valid", {31'h0, valid0}, 32'h1);
      check("bp_last", {31'h0, last0}, 32'h0);
    end
    ready_i = 1'b1;
    cyc(1);
    check("bp_word2", text0, 32'h6a7b0430);
    cyc(2);
    check("bp_busy_end", {31'h0, busy0}, 32'h0);

    // Back-to-back chaining, then an ignored done_i that sets overflow.
    done_i = 1'b1; text_in = BLK_A;
    push_words(32'h70b4c55a, 32'hd8cdb780, 32'h6a7b0430, 32'h69c4e0d8);
    cyc(1);
    done_i = 1'b0;
    cyc(3);
    check("b2b_last_word", text0, 32'h69c4e0d8);
    check("b2b_last_flag", {31'h0, last0}, 32'h1);
    done_i = 1'b1; text_in = BLK_B;
    push_words(32'h11111111, 32'h11111111, 32'h11111111, 32'h11111111);
    cyc(1);
    done_i = 1'b0;
    check("b2b_next_word", text0, 32'h11111111);
    check("b2b_valid", {31'h0, valid0}, 32'h1);
    check("b2b_ovf", {31'h0, ovf0}, 32'h0);
    cyc(1);
    done_i = 1'b1; text_in = BLK_C;
    cyc(1);
    done_i = 1'b0; text_in = 128'h0;
    check("ovf_set", {31'h0, ovf0}, 32'h1);
    check("ovf_hold_text", text0, 32'h11111111);
    check("ovf_hold_text1", text1, 32'h11111111);
    cyc(2);
    check("ovf_busy_end", {31'h0, busy0}, 32'h0);
    check("ovf_sticky", {31'h0, ovf0}, 32'h1);

    // Asynchronous reset mid-block at idx=2.
    done_i = 1'b1; text_in = BLK_A;
    push_words(32'h70b4c55a, 32'hd8cdb780, 32'h6a7b0430, 32'h69c4e0d8);
    cyc(1);
    done_i = 1'b0;
    cyc(2);
    check("pre_rst_word2", text0, 32'h6a7b0430);
    #2;
    rst = 1'b0;
    #1;
    check_zero("mid_rst");
    q0.delete(); q1.delete();
    cyc(1);
    rst = 1'b1;
    done_i = 1'b1; text_in = BLK_D;
    push_words(32'hccddeeff, 32'h8899aabb, 32'h44556677, 32'h00112233);
    cyc(1);
    done_i = 1'b0;
    check("post_rst_word0", text0, 32'hccddeeff);
    check("post_rst_word0_msw", text1, 32'h00112233);
    check("post_rst_valid", {31'h0, valid0}, 32'h1);
    cyc(4);
    check("post_rst_busy_end", {31'h0, busy0}, 32'h0);

    check("sb0_drained", q0.size(), 32'd0);
    check("sb1_drained", q1.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_aes_output_buffer

// File: doc/aes_output_buffer.md
AES_OUTPUT_BUFFER -- requirements
Module: aes_output_buffer

Interface
REQ-001 Parameter: MSW_FIRST, default 0, 0 sends text_in[31:0] first and 1 sends text_in[127:96] first.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-low.
REQ-004 Port: done_i  input  1  one-cycle pulse from the AES core marking text_in valid.
REQ-005 Port: text_in  input  128  result block from the AES core, sampled only when done_i=1.
REQ-006 Port: ready_i  input  1  downstream consumer accepts the current word.
REQ-007 Port: text_o  output  32  current output word.
REQ-008 Port: valid_o  output  1  text_o holds a valid word.
REQ-009 Port: last_o  output  1  the current word is the 4th word of the block.
REQ-010 Port: busy_o  output  1  a block is held or being sent.
REQ-011 Port: ovf_o  output  1  sticky flag: a done_i pulse was dropped.

Function
REQ-012 The block SHALL use two states: IDLE and SEND, plus a 2-bit word index idx and a 128-bit holding register.
REQ-013 In IDLE, done_i=1 SHALL capture text_in, clear idx to 0 and enter SEND on the same edge.
- Latency: done_i high at cycle N gives valid_o high at cycle N+1.
REQ-014 In SEND, valid_o SHALL be 1 and text_o SHALL equal holding word idx, ordered per MSW_FIRST.
REQ-015 A transfer SHALL occur on a cycle with valid_o=1 and ready_i=1.
- Each transfer increments idx.
REQ-016 While ready_i=0, text_o, valid_o and last_o SHALL stay stable; valid_o is never retracted.
REQ-017 last_o SHALL equal 1 exactly when state=SEND and idx=3.
REQ-018 A transfer at idx=3 SHALL return the block to IDLE, unless REQ-019 applies.
REQ-019 A done_i in the same cycle as the idx=3 transfer SHALL capture the new text_in, reset idx to 0 and stay in SEND.
- No bubble: the next cycle presents word 0 of the new block.
REQ-020 Any other done_i while in SEND SHALL be ignored.
- The holding register is unchanged.
- ovf_o is set to 1 and stays 1 until reset.
REQ-021 busy_o SHALL equal 1 whenever state=SEND.
REQ-022 In IDLE, valid_o and last_o SHALL be 0 and text_o SHALL be 0.
REQ-023 ready_i SHALL have no effect in IDLE.

Reset
REQ-024 rst=0 SHALL asynchronously force all of the following, regardless of clk:
- state=IDLE, idx=0, holding register=0;
- text_o=0, valid_o=0, last_o=0, busy_o=0, ovf_o=0.
REQ-025 Reset asserted mid-block SHALL abandon the block with no further words.
- After rst deasserts, the first done_i is handled as in REQ-013.
REQ-026 done_i arriving in the first clk edge after rst deasserts SHALL be honoured.

Structure
REQ-027 The state enum (IDLE, SEND), the word count constant (4) and the word width constant (32) SHALL live in the shared package aes_pkg.
- The input buffer uses the same package.
REQ-028 No sub-module SHALL be used.
- The 4:1 word select is an inline mux indexed by idx and MSW_FIRST.

Verification
REQ-029 Basic order: MSW_FIRST=0, text_in=69c4e0d86a7b0430d8cdb78070b4c55a, done_i pulse, ready_i=1.
- Words 70b4c55a, d8cdb780, 6a7b0430, 69c4e0d8 on 4 consecutive cycles starting at N+1.
- last_o high only on 69c4e0d8.
- busy_o falls after the last word.
REQ-030 Reverse order: MSW_FIRST=1 with the same block.
- Words 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a.
REQ-031 Backpressure: ready_i=0 for 3 cycles during word 1.
- text_o stays d8cdb780 and valid_o stays 1 throughout.
- Word 2 follows one cycle after ready_i rises.
REQ-032 Back-to-back and overflow:
- done_i with block B (all words 11111111) coincident with the word-3 transfer of block A: word 11111111 appears the next cycle, ovf_o stays 0.
- A further done_i at idx=1: ignored, ovf_o becomes 1 and stays 1.
REQ-033 Reset mid-operation: rst=0 between clock edges at idx=2.
- All outputs are 0 immediately, without waiting for clk.
- After release, a new done_i yields word 0 of the new block at N+1.
